// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Loads a CHAIN_LEN-bit configuration scan chain from a DATA_W-bit
//   valid/ready bitstream, LSB of each word first. The bits that come out of
//   the chain tail during the load (the previous contents) are collected and
//   returned as readback words.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             1-cycle pulse, begins a full-chain load (ignored while busy)
//   s_data/s_valid/   bitstream word stream; one word accepted per FETCH visit
//   s_ready
//   rd_data/rd_valid  readback word (old chain bits), 1-cycle valid pulse
//   busy, done        load in progress / 1-cycle completion pulse
//   prog_in/prog_clk/ serial chain interface; prog_clk is a generated strobe
//   prog_en/prog_out
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_FETCH  | s_ready high, waiting for the next bitstream word
//   S_LOW    | prog_clk low, prog_in = current bit, prog_out sampled on last cycle
//   S_HIGH   | prog_clk high, prog_in held, chain shifts on the rising edge
//   S_FINISH | chain released, done pulse
module config_chain_loader #(
  parameter int CHAIN_LEN = 19,
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out
);

  localparam int NWORDS    = (CHAIN_LEN + DATA_W - 1) / DATA_W;
  localparam int LAST_BITS = ((CHAIN_LEN % DATA_W) == 0) ? DATA_W : (CHAIN_LEN % DATA_W);
  localparam int BIT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WORD_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0]  FULL_IDX  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  LAST_IDX  = BIT_W'(LAST_BITS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NWORDS - 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rd_word;
  logic [BIT_W-1:0]  bit_idx;
  logic [WORD_W-1:0] word_idx;
  logic [DIV_W-1:0]  div_cnt;

  logic div_tc;
  logic last_word;
  logic word_end;

  assign div_tc    = (div_cnt == '0);
  assign last_word = (word_idx == LAST_WORD);
  // The final word only carries LAST_BITS valid bits; the rest are ignored.
  assign word_end  = (bit_idx == (last_word ? LAST_IDX : FULL_IDX));
  assign rd_data   = rd_word;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    prog_in   = 1'b0;
    prog_clk  = 1'b0;
    prog_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        prog_en = 1'b1;
        if (s_valid) state_nxt = S_LOW;
      end
      S_LOW: begin
        busy    = 1'b1;
        prog_en = 1'b1;
        prog_in = word_q[bit_idx];
        if (div_tc) state_nxt = S_HIGH;
      end
      S_HIGH: begin
        busy     = 1'b1;
        prog_en  = 1'b1;
        prog_clk = 1'b1;
        prog_in  = word_q[bit_idx];
        if (div_tc) begin
          if (!word_end)     state_nxt = S_LOW;
          else if (last_word) state_nxt = S_FINISH;
          else               state_nxt = S_FETCH;
        end
      end
      S_FINISH: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      word_q   <= '0;
      rd_word  <= '0;
      bit_idx  <= '0;
      word_idx <= '0;
      div_cnt  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            word_idx <= '0;
            bit_idx  <= '0;
          end
        end
        S_FETCH: begin
          if (s_valid) begin
            word_q  <= s_data;
            // Cleared per word so the short last word reads back zero-padded.
            rd_word <= '0;
            bit_idx <= '0;
            div_cnt <= DIV_LOAD;
          end
        end
        S_LOW: begin
          if (div_tc) begin
            // Tail bit is still the old chain bit: the shift happens on the
            // prog_clk rise that follows this cycle.
            rd_word[bit_idx] <= prog_out;
            rd_valid         <= word_end;
            div_cnt          <= DIV_LOAD;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        S_HIGH: begin
          if (div_tc) begin
            div_cnt <= DIV_LOAD;
            if (!word_end)      bit_idx  <= bit_idx + 1'b1;
            else if (!last_word) word_idx <= word_idx + 1'b1;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
